// File: rtl/gcm_pkg.sv
// Shared types, constants and length helpers for the GCM stream feeder.
package gcm_pkg;

  localparam int BEAT_BYTES = 16;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    KICK,
    AAD,
    PLD,
    FLUSH
  } state_t;

  // One engine beat as held in the output register.
  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
  } beat_t;

  // Host word count for a byte length; computed in 33 bits so 0xFFFFFFFF does not wrap.
  function automatic logic [30:0] word_cnt(input logic [31:0] bytes);
    return 31'(({1'b0, bytes} + 33'd3) >> 2);
  endfunction

  // Keep mask with the top n bytes set (first byte is keep[15]).
  function automatic logic [15:0] keep_of(input logic [4:0] n);
    return ~(16'hFFFF >> n);
  endfunction

endpackage

// File: rtl/gcm_beat_packer.sv
// Packs 32-bit host words into 128-bit beats: accumulator plus output register.
module gcm_beat_packer
  import gcm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        seg_load,
  input  logic [31:0] seg_bytes,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        last_word,
  output logic        out_valid,
  output beat_t       out_beat,
  input  logic        out_ready,
  output logic        seg_done
);

  logic [30:0]  words_left;
  logic [31:0]  bytes_left;
  logic [127:0] acc_data;
  logic [1:0]   acc_idx;
  logic [4:0]   acc_bytes;
  logic         acc_full;
  logic         acc_last;

  logic [2:0]   nb;
  logic [31:0]  wmask;
  logic [127:0] merged;
  logic [4:0]   merged_bytes;
  logic         take;
  logic         beat_done;
  logic         out_free;

  // Merge the incoming word into the accumulator; bytes past the segment end are zeroed.
  always_comb begin
    nb = (bytes_left >= 32'(WORD_BYTES)) ? 3'd4 : bytes_left[2:0];
    wmask = '0;
    for (int b = 0; b < 4; b++)
      if (nb > 3'(b)) wmask[31-8*b -: 8] = 8'hFF;
    merged = acc_data;
    merged[{~acc_idx, 5'b0} +: 32] = in_data & wmask;
    merged_bytes = acc_bytes + {2'b0, nb};
  end

  assign in_ready  = ~acc_full & (words_left != '0);
  assign last_word = (words_left == 31'd1);
  assign take      = in_valid & in_ready;
  assign beat_done = take & ((acc_idx == 2'd3) | last_word);
  assign out_free  = ~out_valid | out_ready;
  assign seg_done  = out_valid & out_ready & out_beat.last;

  // Word counting, accumulator fill and output register hand-off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words_left <= '0;
      bytes_left <= '0;
      acc_data   <= '0;
      acc_idx    <= '0;
      acc_bytes  <= '0;
      acc_full   <= 1'b0;
      acc_last   <= 1'b0;
      out_valid  <= 1'b0;
      out_beat   <= '0;
    end else if (seg_load) begin
      words_left <= word_cnt(seg_bytes);
      bytes_left <= seg_bytes;
      acc_data   <= '0;
      acc_idx    <= '0;
      acc_bytes  <= '0;
      acc_full   <= 1'b0;
      acc_last   <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      if (take) begin
        words_left <= words_left - 31'd1;
        bytes_left <= bytes_left - {29'b0, nb};
      end
      // A completed beat goes straight to the output register when it is free,
      // so the 4th word shows up as valid on the very next cycle.
      if (out_free) begin
        if (acc_full) begin
          out_valid <= 1'b1;
          out_beat  <= '{data: acc_data, keep: keep_of(acc_bytes), last: acc_last};
        end else if (beat_done) begin
          out_valid <= 1'b1;
          out_beat  <= '{data: merged, keep: keep_of(merged_bytes), last: last_word};
        end else begin
          out_valid <= 1'b0;
        end
      end
      if ((acc_full & out_free) | (beat_done & out_free)) begin
        acc_full  <= 1'b0;
        acc_data  <= '0;
        acc_idx   <= '0;
        acc_bytes <= '0;
        acc_last  <= 1'b0;
      end else if (beat_done) begin
        acc_full  <= 1'b1;
        acc_data  <= merged;
        acc_bytes <= merged_bytes;
        acc_last  <= last_word;
      end else if (take) begin
        acc_data  <= merged;
        acc_idx   <= acc_idx + 2'd1;
        acc_bytes <= merged_bytes;
      end
    end
  end

endmodule

// File: rtl/gcm_stream_feeder.sv
// Sequences a host word stream into the GCM engine's AAD and payload ports.
module gcm_stream_feeder
  import gcm_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_start,
  input  logic [31:0]  cfg_aad_bytes,
  input  logic [31:0]  cfg_pld_bytes,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  input  logic         s_last,
  output logic         aad_valid,
  input  logic         aad_ready,
  output logic         aad_last,
  output logic [127:0] aad_data,
  output logic [15:0]  aad_keep,
  output logic         din_valid,
  input  logic         din_ready,
  output logic         din_last,
  output logic [127:0] din_data,
  output logic [15:0]  din_keep,
  output logic         eng_start,
  output logic [63:0]  len_aad_bits,
  output logic [63:0]  len_pld_bits,
  output logic         busy,
  output logic         done,
  output logic         frame_err
);

  state_t      state, nxt;
  logic [31:0] aad_len, pld_len;
  logic        aad_nz, pld_nz, accept;
  logic        seg_active, seg_load;
  logic [31:0] seg_bytes;
  logic        pk_in_ready, pk_last_word, pk_out_valid, pk_out_ready, pk_seg_done;
  beat_t       pk_beat;
  logic        word_acc, final_word;

  assign aad_nz = (aad_len != '0);
  assign pld_nz = (pld_len != '0);
  assign accept = (state == IDLE) & cfg_start;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state: segments are skipped when their length is zero.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (cfg_start) nxt = KICK;
      KICK:  nxt = aad_nz ? AAD : (pld_nz ? PLD : FLUSH);
      AAD:   if (pk_seg_done) nxt = pld_nz ? PLD : FLUSH;
      PLD:   if (pk_seg_done) nxt = FLUSH;
      FLUSH: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; the packer is reloaded on each segment entry.
  always_comb begin
    eng_start    = (state == KICK);
    done         = (state == FLUSH);
    busy         = (state != IDLE);
    seg_active   = (state == AAD) | (state == PLD);
    seg_load     = ((state == KICK) & (aad_nz | pld_nz)) |
                   ((state == AAD) & pk_seg_done & pld_nz);
    seg_bytes    = ((state == KICK) & aad_nz) ? aad_len : pld_len;
    pk_out_ready = (state == AAD) ? aad_ready : ((state == PLD) ? din_ready : 1'b0);
  end

  // Lengths latch only on a cfg_start accepted in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aad_len <= '0;
      pld_len <= '0;
    end else if (accept) begin
      aad_len <= cfg_aad_bytes;
      pld_len <= cfg_pld_bytes;
    end
  end

  assign len_aad_bits = {29'b0, aad_len, 3'b0};
  assign len_pld_bits = {29'b0, pld_len, 3'b0};

  // s_last must mark exactly the frame's final word; a mismatch latches until the next frame.
  assign word_acc   = s_valid & s_ready;
  assign final_word = pk_last_word & ((state == PLD) | ((state == AAD) & ~pld_nz));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 frame_err <= 1'b0;
    else if (accept)                         frame_err <= 1'b0;
    else if (word_acc & (s_last != final_word)) frame_err <= 1'b1;
  end

  gcm_beat_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .seg_load  (seg_load),
    .seg_bytes (seg_bytes),
    .in_valid  (s_valid & seg_active),
    .in_data   (s_data),
    .in_ready  (pk_in_ready),
    .last_word (pk_last_word),
    .out_valid (pk_out_valid),
    .out_beat  (pk_beat),
    .out_ready (pk_out_ready),
    .seg_done  (pk_seg_done)
  );

  assign s_ready   = seg_active & pk_in_ready;
  assign aad_valid = pk_out_valid & (state == AAD);
  assign din_valid = pk_out_valid & (state == PLD);
  assign aad_last  = pk_beat.last & (state == AAD);
  assign din_last  = pk_beat.last & (state == PLD);
  assign aad_data  = pk_beat.data;
  assign din_data  = pk_beat.data;
  assign aad_keep  = pk_beat.keep;
  assign din_keep  = pk_beat.keep;

endmodule

// File: tb/tb_gcm_stream_feeder.sv
// Scoreboard bench for gcm_stream_feeder: directed frames, expected beats queued at issue.
module tb_gcm_stream_feeder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_start = 1'b0;
  logic [31:0]  cfg_aad_bytes = '0, cfg_pld_bytes = '0;
  logic         s_valid = 1'b0, s_last = 1'b0;
  logic [31:0]  s_data = '0;
  logic         s_ready;
  logic         aad_valid, aad_last, din_valid, din_last;
  logic         aad_ready = 1'b1;
  logic         din_ready = 1'b1;
  logic [127:0] aad_data, din_data;
  logic [15:0]  aad_keep, din_keep;
  logic         eng_start, busy, done, frame_err;
  logic [63:0]  len_aad_bits, len_pld_bits;

  always #5 clk = ~clk;

  gcm_stream_feeder dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start),
    .cfg_aad_bytes(cfg_aad_bytes), .cfg_pld_bytes(cfg_pld_bytes),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .aad_valid(aad_valid), .aad_ready(aad_ready), .aad_last(aad_last),
    .aad_data(aad_data), .aad_keep(aad_keep),
    .din_valid(din_valid), .din_ready(din_ready), .din_last(din_last),
    .din_data(din_data), .din_keep(din_keep),
    .eng_start(eng_start), .len_aad_bits(len_aad_bits), .len_pld_bits(len_pld_bits),
    .busy(busy), .done(done), .frame_err(frame_err)
  );

  typedef struct {
    bit           seg;
    logic [127:0] data;
    logic [15:0]  keep;
    bit           last;
  } exp_t;

  exp_t        sb[$];
  int          errs = 0, checks = 0;
  int          cyc = 0;
  int          words_acc = 0, valid_cnt = 0, sready_cnt = 0, last_xfer = -1;
  bit          tgl = 1'b0;
  logic [31:0] hw[16];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Engine payload ready: either held high or toggled every cycle.
  always @(posedge clk) begin
    #1;
    din_ready = tgl ? ~din_ready : 1'b1;
  end

  // Monitor: pops the scoreboard on every transfer and checks hold stability.
  logic         hold = 1'b0;
  logic [145:0] hd = '0;
  always @(negedge clk) begin
    logic         v, r, sg, lst;
    logic [127:0] d;
    logic [15:0]  k;
    exp_t         e;
    if (rst) begin
      hold <= 1'b0;
    end else begin
      v   = aad_valid | din_valid;
      r   = din_valid ? din_ready : aad_ready;
      sg  = din_valid;
      d   = din_valid ? din_data : aad_data;
      k   = din_valid ? din_keep : aad_keep;
      lst = din_valid ? din_last : aad_last;
      if (v) chk("one_port_valid", 160'(aad_valid & din_valid), 160'(0));
      if (hold) chk("hold_stable", 160'({v, sg, d, k, lst}), 160'({1'b1, hd}));
      if (v & r) begin
        if (sb.size() == 0) begin
          errs++; checks++;
          $display("FAIL unexpected_beat: got %h with nothing expected", d);
        end else begin
          e = sb.pop_front();
          chk("beat", 160'({sg, d, k, lst}), 160'({e.seg, e.data, e.keep, e.last}));
        end
        last_xfer <= cyc;
      end
      hold <= v & ~r;
      hd   <= {sg, d, k, lst};
      if (v) valid_cnt <= valid_cnt + 1;
      if (s_ready) sready_cnt <= sready_cnt + 1;
      if (s_valid & s_ready) words_acc <= words_acc + 1;
    end
  end

  task automatic push(input bit seg, input logic [127:0] d, input logic [15:0] k, input bit l);
    exp_t e;
    e.seg = seg; e.data = d; e.keep = k; e.last = l;
    sb.push_back(e);
  endtask

  task automatic fill(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = base + 8'(4 * i);
      hw[i] = {b, b + 8'd1, b + 8'd2, b + 8'd3};
    end
  endtask

  // Pulse cfg_start; returns during the KICK cycle.
  task automatic start(input logic [31:0] a, input logic [31:0] p);
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_aad_bytes = a; cfg_pld_bytes = p;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic feed(input int n, input int last_idx);
    for (int i = 0; i < n; i++) begin
      bit ok;
      int to;
      s_valid = 1'b1; s_data = hw[i]; s_last = (i == last_idx);
      ok = 1'b0; to = 0;
      while (!ok && to < 300) begin
        @(negedge clk);
        if (s_ready) ok = 1'b1; else to++;
      end
      if (!ok) begin
        errs++; checks++;
        $display("FAIL feed_timeout: word %0d never accepted", i);
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
  endtask

  task automatic wait_done(output int dc);
    int n;
    n = 0; dc = -1;
    while (n < 400) begin
      @(negedge clk);
      if (done) begin dc = cyc; break; end
      n++;
    end
    chk("done_seen", 160'(dc >= 0), 160'(1));
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_ctrl"}, 160'({busy, done, frame_err, eng_start, aad_valid, din_valid,
                              s_ready, aad_last, din_last, aad_keep, din_keep}), 160'(0));
    chk({tag, "_len"}, 160'({len_aad_bits, len_pld_bits}), 160'(0));
    chk({tag, "_aad_data"}, 160'(aad_data), 160'(0));
    chk({tag, "_din_data"}, 160'(din_data), 160'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, w0, v0, r0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 outs_zero("reset");
    @(negedge clk) rst = 1'b0;

    // aad=16, pld=32, ready high; a cfg_start while busy is ignored
    w0 = words_acc;
    start(32'd16, 32'd32);
    chk("a_eng_start", 160'(eng_start), 160'(1));
    chk("a_lens", 160'({len_aad_bits, len_pld_bits}), 160'({64'd128, 64'd256}));
    cfg_start = 1'b1; cfg_aad_bytes = 32'd99; cfg_pld_bytes = 32'd99;
    @(posedge clk); #1 cfg_start = 1'b0;
    chk("a_busy_ignore", 160'({busy, len_aad_bits, len_pld_bits}), 160'({1'b1, 64'd128, 64'd256}));
    push(1'b0, 128'h000102030405060708090A0B0C0D0E0F, 16'hFFFF, 1'b1);
    push(1'b1, 128'h101112131415161718191A1B1C1D1E1F, 16'hFFFF, 1'b0);
    push(1'b1, 128'h202122232425262728292A2B2C2D2E2F, 16'hFFFF, 1'b1);
    fill(8'h00, 4); feed(4, -1);
    fill(8'h10, 8); feed(8, 7);
    wait_done(dc);
    chk("a_done_latency", 160'(dc), 160'(last_xfer + 1));
    chk("a_words", 160'(words_acc - w0), 160'(12));
    chk("a_frame_err", 160'(frame_err), 160'(0));
    chk("a_sb_empty", 160'(sb.size()), 160'(0));

    // aad=5, pld=13: partial final beats
    w0 = words_acc;
    start(32'd5, 32'd13);
    chk("b_lens", 160'({len_aad_bits, len_pld_bits}), 160'({64'd40, 64'd104}));
    push(1'b0, 128'hA0A1A2A3_A4000000_00000000_00000000, 16'hF800, 1'b1);
    push(1'b1, 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BC000000, 16'hFFF8, 1'b1);
    fill(8'hA0, 2); feed(2, -1);
    fill(8'hB0, 4); feed(4, 3);
    wait_done(dc);
    chk("b_words", 160'(words_acc - w0), 160'(6));
    chk("b_frame_err", 160'(frame_err), 160'(0));
    chk("b_sb_empty", 160'(sb.size()), 160'(0));

    // aad=0, pld=0: KICK then FLUSH, nothing moves
    v0 = valid_cnt; r0 = sready_cnt;
    start(32'd0, 32'd0);
    chk("c_eng_start", 160'(eng_start), 160'(1));
    @(posedge clk); #1;
    chk("c_done", 160'({done, eng_start}), 160'({1'b1, 1'b0}));
    @(posedge clk); #1;
    chk("c_idle", 160'({done, busy}), 160'(0));
    @(negedge clk);
    chk("c_no_valid", 160'(valid_cnt - v0), 160'(0));
    chk("c_no_sready", 160'(sready_cnt - r0), 160'(0));

    // pld=64 with din_ready toggling
    w0 = words_acc;
    tgl = 1'b1;
    start(32'd0, 32'd64);
    push(1'b1, 128'h404142434445464748494A4B4C4D4E4F, 16'hFFFF, 1'b0);
    push(1'b1, 128'h505152535455565758595A5B5C5D5E5F, 16'hFFFF, 1'b0);
    push(1'b1, 128'h606162636465666768696A6B6C6D6E6F, 16'hFFFF, 1'b0);
    push(1'b1, 128'h707172737475767778797A7B7C7D7E7F, 16'hFFFF, 1'b1);
    fill(8'h40, 16); feed(16, 15);
    wait_done(dc);
    tgl = 1'b0;
    chk("d_words", 160'(words_acc - w0), 160'(16));
    chk("d_sb_empty", 160'(sb.size()), 160'(0));

    // s_last on the 2nd of 4 payload words
    w0 = words_acc;
    start(32'd0, 32'd16);
    push(1'b1, 128'h808182838485868788898A8B8C8D8E8F, 16'hFFFF, 1'b1);
    fill(8'h80, 4); feed(4, 1);
    wait_done(dc);
    chk("e_frame_err_set", 160'(frame_err), 160'(1));
    chk("e_words", 160'(words_acc - w0), 160'(4));
    repeat (3) @(posedge clk);
    #1 chk("e_frame_err_sticky", 160'(frame_err), 160'(1));
    start(32'd0, 32'd4);
    chk("e_frame_err_clear", 160'(frame_err), 160'(0));
    push(1'b1, 128'h90919293_00000000_00000000_00000000, 16'hF000, 1'b1);
    fill(8'h90, 1); feed(1, 0);
    wait_done(dc);
    chk("e_frame_err_ok", 160'(frame_err), 160'(0));

    // Reset during the 3rd payload word, then a clean aad=4, pld=4 frame
    start(32'd0, 32'd16);
    fill(8'hC0, 3); feed(2, -1);
    s_valid = 1'b1; s_data = hw[2];
    @(negedge clk); #2 rst = 1'b1;
    #1 outs_zero("midrst");
    sb.delete();
    s_valid = 1'b0; s_data = '0;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("f_idle_after_rst", 160'({busy, s_ready}), 160'(0));
    start(32'd4, 32'd4);
    chk("f_lens", 160'({len_aad_bits, len_pld_bits}), 160'({64'd32, 64'd32}));
    push(1'b0, 128'hD0D1D2D3_00000000_00000000_00000000, 16'hF000, 1'b1);
    push(1'b1, 128'hE0E1E2E3_00000000_00000000_00000000, 16'hF000, 1'b1);
    fill(8'hD0, 1); feed(1, -1);
    fill(8'hE0, 1); feed(1, 0);
    wait_done(dc);
    chk("f_frame_err", 160'(frame_err), 160'(0));
    chk("f_sb_empty", 160'(sb.size()), 160'(0));

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
